pwm_duty_decoder: RTL and testbench
===================================

# pwm_duty_decoder

Measures the duty cycle of a single motor PWM line and reports it as an RPM code of the same width the PWM generator accepts. Each measurement window is 2**WIDTH clock cycles, which equals the generator period, so the high-cycle count is independent of window phase. Sits on the receive side of the motor PWM link: ESC-side model, loopback self-check, and bench scoreboard input.

## Interface

- WIDTH, 7: RPM code width; window length is 2**WIDTH cycles.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer, minimum 2.
- FILTER_LEN, 3: stable-cycle count for the glitch filter; used only when the filter is compiled in; minimum 2.

- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-high.
- enable  in  1  level; measurement runs while high.
- pwm_in  in  1  PWM line, asynchronous to clk.
- duty  out  WIDTH  last completed measurement, saturated.
- duty_valid  out  1  one-cycle pulse when duty updates.
- stuck_high  out  1  last window was high every cycle.
- stuck_low  out  1  last window was low every cycle.
- busy  out  1  high in SYNC and MEASURE.

## Operation

- pwm_in passes through a SYNC_STAGES synchronizer, plus the glitch filter when enabled; the result is pwm_s.
- States:
  - IDLE: counters cleared. enable=1 moves to SYNC.
  - SYNC: discards SYNC_STAGES cycles, plus FILTER_LEN when filtered, to flush the pipeline. Then moves to MEASURE.
  - MEASURE: win_cnt (WIDTH bits) increments every cycle. hi_cnt (WIDTH+1 bits) increments when pwm_s=1.
- Window end is the cycle where win_cnt == 2**WIDTH-1. At that edge:
  - final = hi_cnt + pwm_s, range 0..2**WIDTH.
  - duty = min(final, 2**WIDTH-1).
  - stuck_high = (final == 2**WIDTH).
  - stuck_low = (final == 0).
  - duty_valid=1 for exactly the next cycle.
  - hi_cnt clears, win_cnt wraps to 0, and the next window starts immediately with no gap.
- enable=0 in any state: IDLE on the next edge. The current window is aborted with no duty_valid. duty and the stuck flags hold their last values.
- Re-enabling always passes through SYNC before measuring. Partial windows are never reported.

## Timing

- Reset values: duty=0, duty_valid=0, stuck_high=0, stuck_low=0, busy=0, state=IDLE, all counters and synchronizer/filter flops 0.
- Reset mid-operation: immediate return to reset values. No valid pulse is emitted.
- The first duty_valid comes 1 + SYNC + 2**WIDTH cycles after the enable rising edge is sampled. Later pulses follow every 2**WIDTH cycles.
- pwm_in to pwm_s latency: SYNC_STAGES cycles, plus FILTER_LEN-1 when filtered.
- duty changes only in the cycle where duty_valid=1 and is stable otherwise.
- busy=1 from the cycle after enable is sampled high until the cycle after enable is sampled low.

## Configuration

- PWM_DUTY_DECODER_GLITCH_FILTER_EN defined:
  - pwm_s changes only after the synchronized input has held the new value for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN are dropped.
- Undefined: pwm_s is the synchronizer output directly. FILTER_LEN is ignored and SYNC lasts SYNC_STAGES cycles.

## Structure

- Shared package pwm_pkg holds:
  - the state enum typedef (IDLE, SYNC, MEASURE);
  - PWM_RPM_WIDTH = 7, shared with the generator;
  - the rpm_t typedef;
  - a window-length function, 2**width.
- One sub-module, pwm_sync_filter: synchronizer plus the optional glitch filter, guarded by the macro.
- The FSM and counters stay in the top module.

## Test plan

- Generator at rpm=40, enable held high → every window reports duty=40, stuck flags 0, valid pulses exactly 128 cycles apart.
- pwm_in held 1 → duty=127, stuck_high=1. pwm_in held 0 → duty=0, stuck_low=1.
- Generator rpm stepped 10→100 mid-window → one transitional value between 10 and 100, then 100 on all later windows.
- enable dropped at win_cnt=60 → no duty_valid, duty holds the previous value. After re-enable, the first valid comes 1 + SYNC + 128 cycles after enable is sampled high.
- resetn asserted mid-MEASURE → all outputs 0 immediately. After release, no valid until a full window completes.
- Single-cycle high pulses every 8 cycles, otherwise low → duty=16 without the filter; duty=0 with PWM_DUTY_DECODER_GLITCH_FILTER_EN and stuck_low=1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the motor PWM link (generator and decoder side).
// Holds the RPM code width, the decoder FSM state encoding and the
// window-length helper so both ends agree on the PWM period.
package pwm_pkg;

    // RPM code width shared with the PWM generator.
    localparam int PWM_RPM_WIDTH = 7;

    typedef logic [PWM_RPM_WIDTH-1:0] rpm_t;

    // Decoder FSM states.
    typedef enum logic [1:0] {
        PWM_ST_IDLE    = 2'd0,
        PWM_ST_SYNC    = 2'd1,
        PWM_ST_MEASURE = 2'd2
    } pwm_state_t;

    // One PWM period / measurement window is 2**width clock cycles.
    function automatic int unsigned pwm_window_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/pwm_sync_filter.sv
// Input conditioning for the asynchronous PWM line: a SYNC_STAGES-deep
// synchronizer, optionally followed by a glitch filter.
// Optional feature macro: PWM_DUTY_DECODER_GLITCH_FILTER_EN
//   defined   : output changes only after the synchronized input has held
//               the new value for FILTER_LEN consecutive cycles; latency is
//               SYNC_STAGES + FILTER_LEN - 1.
//   undefined : output is the synchronizer output; latency SYNC_STAGES.
module pwm_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    // Elaboration-time guard on the minimum depths.
    if (SYNC_STAGES < 2 || FILTER_LEN < 2) begin : g_bad_params
        $error("pwm_sync_filter: SYNC_STAGES and FILTER_LEN must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;

    // Shift the raw line into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Synchronizer flops; cleared on reset so the chain starts at 0.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_DUTY_DECODER_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN);

    logic           filt_q;
    logic           filt_d;
    logic [FCW-1:0] fcnt_q;
    logic [FCW-1:0] fcnt_d;
    logic           flip;

    // Count consecutive cycles the synchronized input disagrees with the
    // filtered value; on the FILTER_LEN-th such cycle pass the new value
    // straight through so the filter adds only FILTER_LEN-1 cycles.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        flip   = 1'b0;
        if (sync_out != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                flip   = 1'b1;
                filt_d = sync_out;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        dout = flip ? sync_out : filt_q;
    end

    // Filter state flops.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end
`else
    // No filter: the synchronizer output is the conditioned line.
    always_comb begin
        dout = sync_out;
    end
`endif

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures the duty cycle of one motor PWM line over back-to-back windows
// of 2**WIDTH cycles and reports it as a saturated RPM code.
// Optional feature macro: PWM_DUTY_DECODER_GLITCH_FILTER_EN (glitch filter
// in the input path; also lengthens the SYNC flush by FILTER_LEN cycles).
import pwm_pkg::*;

module pwm_duty_decoder #(
    parameter int WIDTH       = PWM_RPM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic             busy
);

    localparam int WIN_LEN = pwm_window_len(WIDTH);

`ifdef PWM_DUTY_DECODER_GLITCH_FILTER_EN
    localparam int SYNC_LEN = SYNC_STAGES + FILTER_LEN;
`else
    localparam int SYNC_LEN = SYNC_STAGES;
`endif

    localparam int SCW = $clog2(SYNC_LEN + 1);

    localparam logic [1:0] ST_IDLE    = PWM_ST_IDLE;
    localparam logic [1:0] ST_SYNC    = PWM_ST_SYNC;
    localparam logic [1:0] ST_MEASURE = PWM_ST_MEASURE;

    localparam logic [WIDTH-1:0] WIN_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   WIN_FULL = (WIDTH + 1)'(WIN_LEN);

    logic             pwm_s;

    logic [1:0]       state_q,      state_d;
    logic [SCW-1:0]   sync_cnt_q,   sync_cnt_d;
    logic [WIDTH-1:0] win_cnt_q,    win_cnt_d;
    logic [WIDTH:0]   hi_cnt_q,     hi_cnt_d;
    logic [WIDTH-1:0] duty_q,       duty_d;
    logic             duty_valid_q, duty_valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q,  stuck_low_d;
    logic [WIDTH:0]   final_cnt;

    pwm_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk    (clk),
        .resetn (resetn),
        .din    (pwm_in),
        .dout   (pwm_s)
    );

    // High-cycle count including the current cycle; at the last window
    // cycle this is the window total, 0..2**WIDTH.
    assign final_cnt = hi_cnt_q + {{WIDTH{1'b0}}, pwm_s};

    // FSM and counters: flush the input pipeline, then measure windows
    // back to back; dropping enable aborts without a report.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        win_cnt_d    = win_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        case (state_q)
            ST_IDLE: begin
                sync_cnt_d = '0;
                win_cnt_d  = '0;
                hi_cnt_d   = '0;
                if (enable) begin
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    sync_cnt_d = '0;
                end else if (sync_cnt_q == SCW'(SYNC_LEN - 1)) begin
                    state_d    = ST_MEASURE;
                    sync_cnt_d = '0;
                    win_cnt_d  = '0;
                    hi_cnt_d   = '0;
                end else begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                end
            end

            ST_MEASURE: begin
                if (!enable) begin
                    state_d   = ST_IDLE;
                    win_cnt_d = '0;
                    hi_cnt_d  = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    // Window end: report, then start the next window at once.
                    duty_d       = (final_cnt == WIN_FULL) ? WIN_LAST
                                                           : final_cnt[WIDTH-1:0];
                    stuck_high_d = (final_cnt == WIN_FULL);
                    stuck_low_d  = (final_cnt == '0);
                    duty_valid_d = 1'b1;
                    win_cnt_d    = '0;
                    hi_cnt_d     = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    hi_cnt_d  = final_cnt;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                sync_cnt_d = '0;
                win_cnt_d  = '0;
                hi_cnt_d   = '0;
            end
        endcase
    end

    // State, counter and result registers; resetn high clears everything.
    always_ff @(posedge clk or posedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (resetn) begin
            state_q      <= ST_IDLE;
            sync_cnt_q   <= '0;
            win_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            win_cnt_q    <= win_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed, scoreboard-based bench for pwm_duty_decoder.
// Honours PWM_DUTY_DECODER_GLITCH_FILTER_EN for the glitch case and the
// SYNC flush length.
module tb_pwm_duty_decoder;

    localparam int WIDTH       = 7;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;
    localparam int WIN         = 1 << WIDTH;
`ifdef PWM_DUTY_DECODER_GLITCH_FILTER_EN
    localparam int SYNC_LEN = SYNC_STAGES + FILTER_LEN;
`else
    localparam int SYNC_LEN = SYNC_STAGES;
`endif

    logic             clk;
    logic             resetn;
    logic             enable;
    logic             pwm_in;
    logic [WIDTH-1:0] duty;
    logic             duty_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic             busy;

    pwm_duty_decoder #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .busy       (busy)
    );

    typedef struct {
        bit skip;   // transitional window: consume without checking
        int lo;
        int hi;
        bit sh;
        bit sl;
    } exp_t;

    exp_t sb[$];

    int n_cmp          = 0;
    int n_fail         = 0;
    int n_valid        = 0;
    int cyc            = 0;
    int last_valid_cyc = 0;

    // Generator controls: 0 = PWM at rpm, 1 = held high, 2 = held low,
    // 3 = one-cycle pulse every 8 cycles.
    int mode    = 0;
    int rpm     = 40;
    int gen_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference PWM generator with a 2**WIDTH period.
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            gen_cnt = (gen_cnt + 1) % WIN;
            case (mode)
                0:       pwm_in = (gen_cnt < rpm);
                1:       pwm_in = 1'b1;
                2:       pwm_in = 1'b0;
                default: pwm_in = ((gen_cnt % 8) == 0);
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] got, input int lo, input int hi);
        n_cmp++;
        assert (got >= lo && got <= hi) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic push_exp(input bit skip, input int lo, input int hi, input bit sh, input bit sl);
        exp_t e;
        e.skip = skip;
        e.lo   = lo;
        e.hi   = hi;
        e.sh   = sh;
        e.sl   = sl;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every duty_valid pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (duty_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_valid: got duty=%0d at cycle %0d expected no pulse", duty, cyc);
                    end
                end else begin
                    e = sb.pop_front();
                    if (!e.skip) begin
                        check_range("duty", duty, e.lo, e.hi);
                        check("stuck_high", stuck_high, e.sh);
                        check("stuck_low", stuck_low, e.sl);
                    end
                end
            end
        end
    end

    task automatic wait_valids(input int n, input int budget);
        int target;
        int t;
        target = n_valid + n;
        t = 0;
        while (n_valid < target && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("valid_within_budget", (n_valid >= target), 1'b1);
    endtask

    // Called with enable already driven high; checks busy around the
    // sampling edge and the latency to the first report.
    task automatic first_valid_latency(input string tag);
        int e0;
        int v0;
        int t;
        check({tag, "_busy_before"}, busy, 1'b0);
        @(posedge clk);
        #1;
        e0 = cyc;
        v0 = n_valid;
        check({tag, "_busy_after"}, busy, 1'b1);
        t = 0;
        while (n_valid == v0 && t < SYNC_LEN + WIN + 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        // Pulse is high in the cycle after edge e0+SYNC+WIN and is captured
        // by edge e0+1+SYNC+WIN.
        check({tag, "_latency"}, last_valid_cyc - e0, SYNC_LEN + WIN);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"}, duty, 0);
        check({tag, "_duty_valid"}, duty_valid, 1'b0);
        check({tag, "_stuck_high"}, stuck_high, 1'b0);
        check({tag, "_stuck_low"}, stuck_low, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int v0;

        resetn = 1'b1;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("after_reset");

        // Steady PWM at rpm=40.
        push_exp(1'b0, 40, 40, 1'b0, 1'b0);
        push_exp(1'b0, 40, 40, 1'b0, 1'b0);
        push_exp(1'b0, 40, 40, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        first_valid_latency("first");
        t1 = last_valid_cyc;
        repeat (50) @(posedge clk);
        #1;
        check("duty_hold_mid_window", duty, 40);
        check("valid_low_mid_window", duty_valid, 1'b0);
        wait_valids(1, WIN + 20);
        check("period_1", last_valid_cyc - t1, WIN);
        t2 = last_valid_cyc;
        wait_valids(1, WIN + 20);
        check("period_2", last_valid_cyc - t2, WIN);

        // Line held high.
        mode = 1;
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
        push_exp(1'b0, WIN - 1, WIN - 1, 1'b1, 1'b0);
        wait_valids(2, 2 * WIN + 20);

        // Line held low.
        mode = 2;
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
        push_exp(1'b0, 0, 0, 1'b0, 1'b1);
        wait_valids(2, 2 * WIN + 20);

        // rpm 10, then step to 100 mid-window.
        mode = 0;
        rpm  = 10;
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
        push_exp(1'b0, 10, 10, 1'b0, 1'b0);
        wait_valids(2, 2 * WIN + 20);
        repeat (64) @(posedge clk);
        #1;
        rpm = 100;
        push_exp(1'b0, 10, 100, 1'b0, 1'b0);
        push_exp(1'b0, 100, 100, 1'b0, 1'b0);
        push_exp(1'b0, 100, 100, 1'b0, 1'b0);
        wait_valids(3, 3 * WIN + 20);

        // Abort at win_cnt=60: no report, results held.
        repeat (60) @(posedge clk);
        #1;
        enable = 1'b0;
        v0 = n_valid;
        @(posedge clk);
        #1;
        check("busy_after_abort", busy, 1'b0);
        repeat (2 * WIN) @(negedge clk);
        #1;
        check("no_valid_after_abort", n_valid - v0, 0);
        check("duty_held_after_abort", duty, 100);
        check("stuck_high_held", stuck_high, 1'b0);
        check("stuck_low_held", stuck_low, 1'b0);
        push_exp(1'b0, 100, 100, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        first_valid_latency("reenable");

        // Reset asserted mid-window.
        repeat (30) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        push_exp(1'b0, 100, 100, 1'b0, 1'b0);
        first_valid_latency("after_mid_reset");

        // Single-cycle glitches every 8 cycles.
        mode = 3;
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
`ifdef PWM_DUTY_DECODER_GLITCH_FILTER_EN
        push_exp(1'b0, 0, 0, 1'b0, 1'b1);
`else
        push_exp(1'b0, 16, 16, 1'b0, 1'b0);
`endif
        wait_valids(2, 2 * WIN + 20);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
